instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage between byte-wide synchronous instruction memory and the cpu core.
//  Accepts a program counter from the cpu and reads the opcode byte plus the two following bytes.
//  Presents them as op_code/arg1/arg2 with a valid/ack handshake.
//  Keeps the last 3-byte window so repeated or sequential (pc+1) fetches need fewer memory reads.
// PARAMETERS
//  ADDR_W  8  width of program counter / memory address; all address arithmetic is mod 2**ADDR_W
//  DATA_W  8  width of one instruction memory byte
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       asynchronous, active-high reset
//  fetch_pc     in   ADDR_W  address of opcode byte to fetch
//  fetch_req    in   1       cpu requests fetch of fetch_pc; accepted on edge where fetch_req & pc_ready
//  pc_ready     out  1       fetch stage can accept a request (state IDLE)
//  flush        in   1       abort current fetch/hold, invalidate window buffer
//  mem_addr     out  ADDR_W  instruction memory read address
//  mem_rd       out  1       read strobe; mem_data valid exactly one cycle after mem_rd & mem_addr
//  mem_data     in   DATA_W  instruction memory read data
//  op_code      out  DATA_W  byte at pc
//  arg1         out  DATA_W  byte at pc+1
//  arg2         out  DATA_W  byte at pc+2
//  instr_valid  out  1       op_code/arg1/arg2 valid; held until instr_ack
//  instr_ack    in   1       cpu consumed instruction; sampled only while instr_valid
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, pc_ready=1, instr_valid=0, mem_rd=0, mem_addr=0.
//    Also op_code=arg1=arg2=0, window buffer invalid, last_pc=0; in-flight reads discarded.
//  - States: IDLE -> FETCH -> HOLD -> IDLE.
//    pc_ready=1 only in IDLE; instr_valid=1 only in HOLD.
//  - On accept (edge E0), request classified against last_pc (buffer valid only):
//    - REPEAT  fetch_pc==last_pc: no memory read; HOLD after E1 (latency 1).
//    - SEQ     fetch_pc==last_pc+1: shift op_code<=arg1, arg1<=arg2.
//              Read fetch_pc+2 only (mem_rd high cycle after E0), capture arg2 at E2; HOLD after E2 (latency 2).
//    - MISS    otherwise / buffer invalid: read pc, pc+1, pc+2 back-to-back (mem_rd high cycles after E0, E1, E2).
//              Capture op_code at E2, arg1 at E3, arg2 at E4; HOLD after E4 (latency 4).
//  - op_code/arg1/arg2 change only on capture edges; stable throughout HOLD.
//  - last_pc<=fetch_pc and buffer valid set when entering HOLD.
//  - mem_rd low whenever no read issued; mem_addr holds last issued address.
//  - HOLD: instr_ack -> IDLE next edge (instr_valid drops, pc_ready rises same edge).
//    A new request is only accepted from IDLE, so ack+req in one cycle does not accept the req.
//  - Address wrap: pc+1, pc+2 mod 2**ADDR_W.
//    pc=0xFF (ADDR_W=8) reads 0xFF,0x00,0x01; last_pc=0xFF, fetch_pc=0x00 is SEQ.
//  - flush (any state, priority over fetch_req/instr_ack): next edge state=IDLE, instr_valid=0, mem_rd=0.
//    Buffer invalidated; data returning from reads already issued is ignored.
//    op_code/arg1/arg2 keep their values but are not valid.
//  - fetch_req while not pc_ready is ignored (cpu must hold it).
//  - fetch_pc sampled only at accept edge.
// TESTING
//  1 MISS: mem[0x10..0x12]=A1,B2,C3, req pc=0x10.
//    -> reads 10,11,12; valid 4 cycles after accept; op=A1 arg1=B2 arg2=C3.
//  2 SEQ: after 1, ack, req 0x11, mem[0x13]=D4.
//    -> single read at 0x13; valid after 2 cycles; op=B2 arg1=C3 arg2=D4.
//  3 REPEAT: after 2, ack, req 0x11.
//    -> no mem_rd; valid after 1 cycle; same bytes B2,C3,D4.
//  4 Wrap: mem[FF]=11, mem[00]=22, mem[01]=33, req 0xFF.
//    -> addrs FF,00,01; op=11 arg1=22 arg2=33. Then req 0x00 -> SEQ, one read at 0x02.
//  5 Flush mid-MISS (after 2nd read issued).
//    -> IDLE next cycle, instr_valid never rises; next req 0x11 is full MISS (3 reads).
//  6 rst asserted mid-FETCH, async.
//    -> outputs 0, pc_ready=1 without clock edge; subsequent fetch behaves as MISS.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads opcode plus two argument bytes from a byte-wide synchronous memory.
// A 3-byte window is kept so that repeated or sequential fetches need fewer memory reads.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_req,
  output logic              pc_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] op_code,
  output logic [DATA_W-1:0] arg1,
  output logic [DATA_W-1:0] arg2,
  output logic              instr_valid,
  input  logic              instr_ack
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  typedef enum logic [1:0] {K_MISS, K_SEQ, K_REPEAT} kind_t;

  state_t            state_reg, state_next;
  kind_t             kind_reg, req_kind;
  logic [1:0]        cnt_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] last_pc_reg;
  logic              buf_valid_reg;
  logic [DATA_W-1:0] op_reg, a1_reg, a2_reg;
  logic              mem_rd_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              fetch_done;

  assign pc_ready    = (state_reg == IDLE);
  assign instr_valid = (state_reg == HOLD);
  assign mem_rd      = mem_rd_reg;
  assign mem_addr    = mem_addr_reg;
  assign op_code     = op_reg;
  assign arg1        = a1_reg;
  assign arg2        = a2_reg;

  always_comb begin
    req_kind = K_MISS;
    if (buf_valid_reg && fetch_pc == last_pc_reg)
      req_kind = K_REPEAT;
    else if (buf_valid_reg && fetch_pc == last_pc_reg + ADDR_W'(1))
      req_kind = K_SEQ;
  end

  // cnt_reg counts edges since accept; the edge where it reads N is edge E(N+1).
  always_comb begin
    fetch_done = 1'b0;
    case (kind_reg)
      K_REPEAT: fetch_done = 1'b1;
      K_SEQ:    fetch_done = (cnt_reg == 2'd1);
      K_MISS:   fetch_done = (cnt_reg == 2'd3);
      default:  fetch_done = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (fetch_req) state_next = FETCH;
        FETCH:   if (fetch_done) state_next = HOLD;
        HOLD:    if (instr_ack) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_reg      <= K_MISS;
      cnt_reg       <= 2'd0;
      pc_reg        <= '0;
      last_pc_reg   <= '0;
      buf_valid_reg <= 1'b0;
      op_reg        <= '0;
      a1_reg        <= '0;
      a2_reg        <= '0;
      mem_rd_reg    <= 1'b0;
      mem_addr_reg  <= '0;
    end else begin
      mem_rd_reg <= 1'b0;
      if (flush) begin
        buf_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (fetch_req) begin
              pc_reg   <= fetch_pc;
              kind_reg <= req_kind;
              cnt_reg  <= 2'd0;
              if (req_kind == K_MISS) begin
                mem_rd_reg   <= 1'b1;
                mem_addr_reg <= fetch_pc;
              end else if (req_kind == K_SEQ) begin
                // Slide the window by one byte; only the new arg2 needs a read.
                op_reg       <= a1_reg;
                a1_reg       <= a2_reg;
                mem_rd_reg   <= 1'b1;
                mem_addr_reg <= fetch_pc + ADDR_W'(2);
              end
            end
          end
          FETCH: begin
            cnt_reg <= cnt_reg + 2'd1;
            if (kind_reg == K_MISS) begin
              case (cnt_reg)
                2'd0: begin
                  mem_rd_reg   <= 1'b1;
                  mem_addr_reg <= pc_reg + ADDR_W'(1);
                end
                2'd1: begin
                  op_reg       <= mem_data;
                  mem_rd_reg   <= 1'b1;
                  mem_addr_reg <= pc_reg + ADDR_W'(2);
                end
                2'd2: a1_reg <= mem_data;
                default: a2_reg <= mem_data;
              endcase
            end else if (kind_reg == K_SEQ && cnt_reg == 2'd1) begin
              a2_reg <= mem_data;
            end
            if (fetch_done) begin
              last_pc_reg   <= pc_reg;
              buf_valid_reg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a driver issues fetches and queues expected responses,
// a monitor pops and checks them when instr_valid rises.
module tb_instr_fetch;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fetch_pc;
  logic       fetch_req;
  logic       pc_ready;
  logic       flush;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic [7:0] op_code, arg1, arg2;
  logic       instr_valid;
  logic       instr_ack;

  instr_fetch #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_req(fetch_req), .pc_ready(pc_ready),
    .flush(flush), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .op_code(op_code), .arg1(arg1), .arg2(arg2), .instr_valid(instr_valid), .instr_ack(instr_ack)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] op;
    logic [7:0] a1;
    logic [7:0] a2;
    int         lat;
    int         acc;
  } exp_t;
  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] rd_log[$];
  logic       prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: log reads, check each new instruction and its stability while held.
  always @(negedge clk) begin
    if (mem_rd) rd_log.push_back(mem_addr);
    if (instr_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got op=%0h arg1=%0h arg2=%0h expected none", op_code, arg1, arg2);
      end else begin
        cur = exp_q.pop_front();
        chk("latency", cyc - cur.acc, cur.lat);
        chk("op_code", op_code, cur.op);
        chk("arg1", arg1, cur.a1);
        chk("arg2", arg2, cur.a2);
        $display("instr pc-latency=%0d op=%0h arg1=%0h arg2=%0h", cyc - cur.acc, op_code, arg1, arg2);
      end
    end else if (instr_valid) begin
      chk("hold_stable", {op_code, arg1, arg2}, {cur.op, cur.a1, cur.a2});
    end
    prev_v = instr_valid;
  end

  task automatic do_fetch(input logic [7:0] pc, input int lat, input logic [7:0] op,
                          input logic [7:0] a1, input logic [7:0] a2, input int nrd,
                          input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
    logic [7:0] ra[3];
    bit got;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    @(negedge clk);
    chk("pc_ready_before", pc_ready, 1);
    rd_log.delete();
    fetch_pc  = pc;
    fetch_req = 1'b1;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    exp_q.push_back('{op, a1, a2, lat, cyc});
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      #1 if (instr_valid) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no instr_valid for pc %0h expected within 12 cycles", pc);
      exp_q.delete();
    end
    chk("read_count", rd_log.size(), nrd);
    for (int i = 0; i < nrd && i < rd_log.size(); i++) chk("read_addr", rd_log[i], ra[i]);
    $display("fetch pc=%0h reads=%0d", pc, rd_log.size());
    repeat (2) @(negedge clk);
    instr_ack = 1'b1;
    @(posedge clk);
    #1 instr_ack = 1'b0;
    chk("ack_valid_low", instr_valid, 0);
    chk("ack_pc_ready", pc_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
    mem[8'hFF] = 8'h11; mem[8'h00] = 8'h22; mem[8'h01] = 8'h33; mem[8'h02] = 8'h44;
    rst = 1'b1; fetch_pc = '0; fetch_req = 0; flush = 0; instr_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc_ready", pc_ready, 1);
    chk("reset_valid", instr_valid, 0);
    chk("reset_mem_rd", mem_rd, 0);
    chk("reset_outputs", {op_code, arg1, arg2, mem_addr}, 0);
    @(negedge clk) rst = 1'b0;

    do_fetch(8'h10, 4, 8'hA1, 8'hB2, 8'hC3, 3, 8'h10, 8'h11, 8'h12);   // MISS
    do_fetch(8'h11, 2, 8'hB2, 8'hC3, 8'hD4, 1, 8'h13, 8'h00, 8'h00);   // SEQ
    do_fetch(8'h11, 1, 8'hB2, 8'hC3, 8'hD4, 0, 8'h00, 8'h00, 8'h00);   // REPEAT

    // Flush after the second read of a MISS is issued.
    @(negedge clk);
    rd_log.delete();
    fetch_pc = 8'h40; fetch_req = 1'b1;
    @(posedge clk); #1 fetch_req = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_pc_ready", pc_ready, 1);
    chk("flush_mem_rd", mem_rd, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_no_valid", instr_valid, 0);
    end
    chk("flush_read_count", rd_log.size(), 2);
    do_fetch(8'h11, 4, 8'hB2, 8'hC3, 8'hD4, 3, 8'h11, 8'h12, 8'h13);   // MISS after flush

    do_fetch(8'hFF, 4, 8'h11, 8'h22, 8'h33, 3, 8'hFF, 8'h00, 8'h01);   // wrap MISS
    do_fetch(8'h00, 2, 8'h22, 8'h33, 8'h44, 1, 8'h02, 8'h00, 8'h00);   // wrap SEQ

    // Asynchronous reset in the middle of a fetch.
    @(negedge clk);
    fetch_pc = 8'h20; fetch_req = 1'b1;
    @(posedge clk); #1 fetch_req = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("async_pc_ready", pc_ready, 1);
    chk("async_valid", instr_valid, 0);
    chk("async_mem_rd", mem_rd, 0);
    chk("async_outputs", {op_code, arg1, arg2, mem_addr}, 0);
    @(negedge clk) rst = 1'b0;
    do_fetch(8'h00, 4, 8'h22, 8'h33, 8'h44, 3, 8'h00, 8'h01, 8'h02);   // MISS after reset

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
